video_tmds_encoder: RTL and testbench

Output stage that sits directly downstream of the video compositor. It takes the registered 12-bit RGB pixel stream with DE, HSYNC, VSYNC and ODDLINE, expands each colour to 8 bits and optionally applies scanline dimming. It then produces three DVI 1.0 TMDS 10-bit symbols per clock, one each for R, G and B. The symbols go to the external 10:1 serializer/PHY, one symbol per pixel clock.

---
 rtl/video_tmds_encoder.sv | 150 +++++++++++++++
 tb/tb_video_tmds_encoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/video_tmds_encoder.sv
// DVI 1.0 TMDS output stage: expands 4-bit RGB to 8 bits, applies optional
// scanline dimming and encodes three 10-bit channel symbols per pixel clock.
module video_tmds_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] video_r,
    input  logic [3:0] video_g,
    input  logic [3:0] video_b,
    input  logic       video_de,
    input  logic       video_hsync,
    input  logic       video_vsync,
    input  logic       video_oddline,
    input  logic       scanline_en,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef struct packed {
        logic [9:0]        sym;
        logic signed [4:0] cnt;
    } enc_t;

    function automatic logic [7:0] expand(input logic [3:0] c, input logic dim);
        logic [7:0] v;
        v = {c, c};
        return dim ? {1'b0, v[7:1]} : v;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = CTRL_00;
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            default: code = CTRL_11;
        endcase
        return code;
    endfunction

    // Transition-minimising stage followed by DC-balancing against the running disparity.
    function automatic enc_t encode_data(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [3:0]        n1;
        logic [3:0]        n1q;
        logic [8:0]        q_m;
        logic signed [5:0] wide;
        logic signed [4:0] diff;
        enc_t              r;
        n1     = popcount8(d);
        q_m    = '0;
        q_m[0] = d[0];
        if (n1 > 4'd4 || (n1 == 4'd4 && !d[0])) begin
            for (int i = 1; i < 8; i++) q_m[i] = ~(q_m[i-1] ^ d[i]);
            q_m[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q_m[i] = q_m[i-1] ^ d[i];
            q_m[8] = 1'b1;
        end

        // n1q - n0q == 2*n1q - 8, always within -8..+8
        n1q  = popcount8(q_m[7:0]);
        wide = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        diff = wide[4:0];

        if (cnt == 5'sd0 || diff == 5'sd0) begin
            r.sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            r.cnt = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
            r.sym = {1'b1, q_m[8], ~q_m[7:0]};
            r.cnt = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            r.sym = {1'b0, q_m[8], q_m[7:0]};
            r.cnt = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
        end
        return r;
    endfunction

    logic [7:0]        d_r_s1, d_g_s1, d_b_s1;
    logic              de_s1, hsync_s1, vsync_s1;
    logic signed [4:0] cnt_r, cnt_g, cnt_b;
    enc_t              enc_r, enc_g, enc_b;
    logic              dim;

    assign dim = scanline_en & video_oddline;

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // the async reset sits in the sensitivity list so outputs clear without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r_s1   <= '0;
            d_g_s1   <= '0;
            d_b_s1   <= '0;
            de_s1    <= 1'b0;
            hsync_s1 <= 1'b0;
            vsync_s1 <= 1'b0;
        end else begin
            d_r_s1   <= expand(video_r, dim);
            d_g_s1   <= expand(video_g, dim);
            d_b_s1   <= expand(video_b, dim);
            de_s1    <= video_de;
            hsync_s1 <= video_hsync;
            vsync_s1 <= video_vsync;
        end
    end

    always_comb begin
        enc_r = encode_data(d_r_s1, cnt_r);
        enc_g = encode_data(d_g_s1, cnt_g);
        enc_b = encode_data(d_b_s1, cnt_b);
    end

    // Disparity clears on the same edge that emits the first control symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmds_r <= CTRL_00;
            tmds_g <= CTRL_00;
            tmds_b <= CTRL_00;
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
        end else if (de_s1) begin
            tmds_r <= enc_r.sym;
            tmds_g <= enc_g.sym;
            tmds_b <= enc_b.sym;
            cnt_r  <= enc_r.cnt;
            cnt_g  <= enc_g.cnt;
            cnt_b  <= enc_b.cnt;
        end else begin
            tmds_r <= CTRL_00;
            tmds_g <= CTRL_00;
            tmds_b <= ctrl_code({vsync_s1, hsync_s1});
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
        end
    end

endmodule

// File: tb/tb_video_tmds_encoder.sv
// Directed bench for video_tmds_encoder with hand-computed TMDS symbols.
module tb_video_tmds_encoder;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] video_r, video_g, video_b;
    logic       video_de, video_hsync, video_vsync, video_oddline, scanline_en;
    logic [9:0] tmds_r, tmds_g, tmds_b;

    int tests_run    = 0;
    int tests_failed = 0;

    video_tmds_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .video_r      (video_r),
        .video_g      (video_g),
        .video_b      (video_b),
        .video_de     (video_de),
        .video_hsync  (video_hsync),
        .video_vsync  (video_vsync),
        .video_oddline(video_oddline),
        .scanline_en  (scanline_en),
        .tmds_r       (tmds_r),
        .tmds_g       (tmds_g),
        .tmds_b       (tmds_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic de, input logic vs, input logic hs,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                      input logic sl, input logic odd);
        video_de      = de;
        video_vsync   = vs;
        video_hsync   = hs;
        video_r       = r;
        video_g       = g;
        video_b       = b;
        scanline_en   = sl;
        video_oddline = odd;
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] er,
                             input logic [9:0] eg, input logic [9:0] eb);
        check({tag, "_r"}, tmds_r, er);
        check({tag, "_g"}, tmds_g, eg);
        check({tag, "_b"}, tmds_b, eb);
    endtask

    initial begin
        // Reset held with a live white pixel on the inputs
        reset = 1'b1;
        px(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        check_all("rst_hold", C00, C00, C00);
        tick();
        reset = 1'b0;
        tick();
        check_all("rst_first", C00, C00, C00);
        tick();
        check_all("white_1", 10'h200, 10'h200, 10'h200);
        tick();
        check_all("white_2", 10'h0FF, 10'h0FF, 10'h0FF);

        // Control codes stepped through {vsync,hsync}
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        px(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("ctrl_00", C00, C00, C00);
        px(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("ctrl_01", C00, C00, C01);
        px(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("ctrl_10", C00, C00, C10);

        // Black run of three pixels from cnt=0
        px(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("ctrl_11", C00, C00, C11);
        tick();
        check_all("black_1", 10'h100, 10'h100, 10'h100);
        tick();
        check_all("black_2", 10'h3FF, 10'h3FF, 10'h3FF);

        // One-clock DE gap, then black again: disparity must restart at 0
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("black_3", 10'h100, 10'h100, 10'h100);
        px(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("gap_ctrl", C00, C00, C00);
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("post_gap", 10'h100, 10'h100, 10'h100);

        // Dimmed white on an odd line, then undimmed white on an even line
        px(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
        tick();
        check_all("pre_dim", C00, C00, C00);
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("dim_odd", 10'b1010000000, 10'b1010000000, 10'b1010000000);
        px(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        tick();
        check_all("pre_even", C00, C00, C00);
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("dim_even", 10'h200, 10'h200, 10'h200);

        // Independent channels, including both n1==4 tie-break paths
        px(1'b1, 1'b0, 1'b0, 4'h3, 4'hC, 4'hF, 1'b0, 1'b0);
        tick();
        check_all("pre_mix", C00, C00, C00);
        px(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("mix", 10'h111, 10'h211, 10'h200);

        // Reset asserted mid-line acts without a clock edge
        px(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        tick();
        check_all("pre_midrst", 10'h200, 10'h200, 10'h200);
        #2;
        reset = 1'b1;
        #1;
        check_all("midrst_async", C00, C00, C00);
        tick();
        reset = 1'b0;
        tick();
        check_all("midrst_first", C00, C00, C00);
        tick();
        check_all("midrst_data", 10'h200, 10'h200, 10'h200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
